spmm_job_sequencer: RTL
=======================

Name: spmm_job_sequencer

Overview:
- Front-end controller for the CSR sparse-matrix-multiply core.
- Accepts one job: a config handshake, then a stream of 32-bit words that fill the six CSR operand arrays (NVA, CIA, RPA, NVB, CIB, RPB) into 512-bit packed buffers.
- Pulses the core's start, waits for completion under a watchdog, then streams the NVC/CIC/RPC results out over a valid/ready port.
- Sits between the host-side stream fabric and the core; it is the only driver of the core's start and operand inputs.

Parameters:
- NNZ_MAX, 16, elements per array; each array is NNZ_MAX x 32 bits = 512 bits.
- DW, 32, stream word width.
- TIMEOUT_CYC, 1024, maximum RUN cycles before abort.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- cfg_valid_i  in  1  job config valid
- cfg_ready_o  out  1  high only in IDLE
- cfg_rows_a_i  in  4  rows of A
- cfg_rows_b_i  in  4  rows of B
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  high only in LOAD
- in_sel_i  in  3  target array: 0 NVA, 1 CIA, 2 RPA, 3 NVB, 4 CIB, 5 RPB; 6-7 reserved
- in_data_i  in  32  operand word
- in_last_i  in  1  final beat of load
- core_start_o  out  1  one-cycle start pulse
- core_rows_a_o, core_rows_b_o  out  4 each  latched config
- core_nva_o, core_cia_o, core_rpa_o, core_nvb_o, core_cib_o, core_rpb_o  out  512 each  packed operands
- core_complete_i  in  1  core op_complete
- core_nvc_i, core_cic_i, core_rpc_i  in  512 each  core results
- out_valid_o  out  1  result beat valid
- out_ready_i  in  1  result sink ready
- out_sel_o  out  2  0 NVC, 1 CIC, 2 RPC
- out_data_o  out  32  result word
- out_last_o  out  1  final result beat
- busy_o  out  1  state != IDLE
- err_timeout_o  out  1  sticky watchdog flag
- err_ovf_o  out  1  sticky overflow/illegal-select flag

Behaviour:
- Reset (asynchronous): state IDLE; all operand buffers, word counters and latched rows cleared to 0.
  - All outputs are 0 except cfg_ready_o, which is 1.
- Packing: element k of every array occupies bits [511-32k : 480-32k], so element 0 is the MSB word.
  - CI/RP arrays carry the value in the low 4 bits of each word; the upper 28 bits are stored as received.
- IDLE:
  - On cfg_valid_i & cfg_ready_o: latch rows, clear all six buffers and six 5-bit word counters, clear both error flags, go to LOAD.
- LOAD:
  - Each in_valid_i beat writes in_data_i at element counter[in_sel_i] of the selected array, then increments that counter.
  - A beat whose counter is already NNZ_MAX, or with in_sel_i >= 6, is dropped and sets err_ovf_o.
  - A beat with in_last_i=1 is processed normally, then the block goes to START.
  - Counters need not be equal; unwritten elements stay 0.
- START:
  - core_start_o = 1 for exactly one cycle, with operands and rows stable; go to RUN.
  - Operand outputs stay stable until the next cfg accept.
- RUN:
  - Watchdog counter increments each cycle.
  - core_complete_i is ignored in the first RUN cycle, because the core clears it on start; a complete still high from the previous job must not be taken.
  - From the second cycle on, core_complete_i = 1 latches core_nvc_i/cic_i/rpc_i into result buffers and goes to UNLOAD.
  - If the counter reaches TIMEOUT_CYC-1 without complete: set err_timeout_o and go to IDLE with no unload.
  - Complete and timeout in the same cycle: complete wins.
- UNLOAD:
  - Streams 48 beats: NVC elements 0..15, then CIC 0..15, then RPC 0..15.
  - CIC and RPC beats carry the 4-bit value zero-extended to 32 bits.
  - A beat transfers when out_valid_o & out_ready_i. Data, sel and last hold steady while stalled.
  - out_last_o is high on the 48th beat; after it transfers, go to IDLE.
- Latency:
  - Config accept to LOAD: 1 cycle.
  - Last load beat to core_start_o: 1 cycle.
  - core_complete_i to first out_valid_o: 1 cycle.
- Reset mid-job:
  - Aborts immediately and core_start_o drops.
  - The core is reset by the same rst_i, so no cleanup handshake is needed.

Optional Feature:
- Macro: SPMM_SEQ_PERF_EN.
- When defined:
  - Adds output perf_cycles_o [15:0] holding the RUN-cycle count of the last completed job, saturating at 16'hFFFF.
  - It is cleared on reset only and updated on complete.
  - Timed-out jobs do not update it.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Identity job, A = B = 2x2 identity:
  - Stimulus: rows 2/2; NVA=[1,1], CIA=[0,1], RPA=[0,1,2], same for B; core model completes after 20 cycles.
  - Expected: exactly one core_start_o pulse; 48 beats with NVC[0..1]=1, CIC[0..1]=[0,1], RPC[0..2]=[0,1,2], all other words 0; out_last_o on beat 48.
- Backpressure:
  - Stimulus: out_ready_i toggled 1/0 every cycle during unload.
  - Expected: 48 beats in order, no duplicates or drops, data held stable while stalled.
- Overflow:
  - Stimulus: 17 NVA beats, then a beat with in_sel_i=7.
  - Expected: err_ovf_o=1, NVA holds only the first 16 words, job still runs.
- Timeout:
  - Stimulus: TIMEOUT_CYC=64, core never completes.
  - Expected: err_timeout_o=1 at RUN cycle 64, return to IDLE, no out_valid_o; next cfg accept clears the flag.
- Stale complete:
  - Stimulus: core_complete_i held 1 from the prior job through the first RUN cycle.
  - Expected: not accepted in that cycle; accepted only when seen high from the second RUN cycle on.
- Reset mid-UNLOAD:
  - Stimulus: assert rst_i at beat 10.
  - Expected: out_valid_o=0 and cfg_ready_o=1 immediately; a new job then completes normally.

Source files
------------

// File: rtl/spmm_job_sequencer.sv
// spmm_job_sequencer: job front-end for the CSR SpMM core (config, operand load, start, watchdog, unload).
// Build option SPMM_SEQ_PERF_EN adds perf_cycles_o, the RUN-cycle count of the last completed job.
module spmm_job_sequencer #(
  parameter int NNZ_MAX     = 16,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [3:0]            cfg_rows_a_i,
  input  logic [3:0]            cfg_rows_b_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            in_sel_i,
  input  logic [DW-1:0]         in_data_i,
  input  logic                  in_last_i,
  output logic                  core_start_o,
  output logic [3:0]            core_rows_a_o,
  output logic [3:0]            core_rows_b_o,
  output logic [NNZ_MAX*DW-1:0] core_nva_o,
  output logic [NNZ_MAX*DW-1:0] core_cia_o,
  output logic [NNZ_MAX*DW-1:0] core_rpa_o,
  output logic [NNZ_MAX*DW-1:0] core_nvb_o,
  output logic [NNZ_MAX*DW-1:0] core_cib_o,
  output logic [NNZ_MAX*DW-1:0] core_rpb_o,
  input  logic                  core_complete_i,
  input  logic [NNZ_MAX*DW-1:0] core_nvc_i,
  input  logic [NNZ_MAX*DW-1:0] core_cic_i,
  input  logic [NNZ_MAX*DW-1:0] core_rpc_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            out_sel_o,
  output logic [DW-1:0]         out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  err_timeout_o,
  output logic                  err_ovf_o
`ifdef SPMM_SEQ_PERF_EN
  ,
  output logic [15:0]           perf_cycles_o
`endif
);

  localparam int BW    = NNZ_MAX * DW;
  localparam int CW    = $clog2(NNZ_MAX + 1);
  localparam int WW    = $clog2(TIMEOUT_CYC + 1);
  localparam int NBEAT = 3 * NNZ_MAX;
  localparam int BCW   = $clog2(NBEAT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_UNLOAD} state_t;
  state_t state, state_nxt;

  logic [BW-1:0]          opbuf [6];
  logic [CW-1:0]          cnt   [6];
  logic [BW-1:0]          nvc_q;
  logic [NNZ_MAX*4-1:0]   cic_q, rpc_q;
  logic [3:0]             rows_a_q, rows_b_q;
  logic [WW-1:0]          wd_q;
  logic [BCW-1:0]         beat_q;
  logic                   err_to_q, err_ovf_q;
  logic                   cfg_fire, in_fire, out_fire, run_done, run_timeout;
  logic                   sel_full, beat_drop, beat_final;
  int                     elem, grp;

  // Only the low nibble of each CI/RP result word is ever streamed out.
  logic unused_res;
  assign unused_res = ^{core_cic_i, core_rpc_i};

  assign cfg_fire    = (state == S_IDLE) && cfg_valid_i;
  assign in_fire     = (state == S_LOAD) && in_valid_i;
  assign out_fire    = (state == S_UNLOAD) && out_ready_i;
  assign beat_final  = (beat_q == BCW'(NBEAT - 1));
  // The first RUN cycle still sees the previous job's complete.
  assign run_done    = (state == S_RUN) && (wd_q != '0) && core_complete_i;
  assign run_timeout = (state == S_RUN) && (wd_q == WW'(TIMEOUT_CYC - 1));

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < 6; i++)
      if ((in_sel_i == 3'(i)) && (cnt[i] == CW'(NNZ_MAX))) sel_full = 1'b1;
  end
  assign beat_drop = (in_sel_i > 3'd5) || sel_full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cfg_valid_i) state_nxt = S_LOAD;
      S_LOAD:   if (in_valid_i && in_last_i) state_nxt = S_START;
      S_START:  state_nxt = S_RUN;
      S_RUN: begin
        if (run_done)         state_nxt = S_UNLOAD;
        else if (run_timeout) state_nxt = S_IDLE;
      end
      S_UNLOAD: if (out_ready_i && beat_final) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_o   = (state == S_IDLE);
    in_ready_o    = (state == S_LOAD);
    core_start_o  = (state == S_START);
    busy_o        = (state != S_IDLE);
    out_valid_o   = (state == S_UNLOAD);
    err_timeout_o = err_to_q;
    err_ovf_o     = err_ovf_q;
    grp           = int'(beat_q) / NNZ_MAX;
    elem          = int'(beat_q) % NNZ_MAX;
    out_sel_o     = 2'd0;
    out_data_o    = '0;
    out_last_o    = 1'b0;
    if (state == S_UNLOAD) begin
      out_last_o = beat_final;
      case (grp)
        0: begin
          out_sel_o  = 2'd0;
          out_data_o = nvc_q[BW-1-DW*elem -: DW];
        end
        1: begin
          out_sel_o  = 2'd1;
          out_data_o = {{(DW-4){1'b0}}, cic_q[4*elem +: 4]};
        end
        default: begin
          out_sel_o  = 2'd2;
          out_data_o = {{(DW-4){1'b0}}, rpc_q[4*elem +: 4]};
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 6; i++) begin
        opbuf[i] <= '0;
        cnt[i]   <= '0;
      end
      nvc_q     <= '0;
      cic_q     <= '0;
      rpc_q     <= '0;
      rows_a_q  <= '0;
      rows_b_q  <= '0;
      wd_q      <= '0;
      beat_q    <= '0;
      err_to_q  <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (cfg_fire) begin
        rows_a_q  <= cfg_rows_a_i;
        rows_b_q  <= cfg_rows_b_i;
        err_to_q  <= 1'b0;
        err_ovf_q <= 1'b0;
        for (int i = 0; i < 6; i++) begin
          opbuf[i] <= '0;
          cnt[i]   <= '0;
        end
      end
      if (in_fire) begin
        if (beat_drop) err_ovf_q <= 1'b1;
        else
          for (int i = 0; i < 6; i++)
            if (in_sel_i == 3'(i)) begin
              opbuf[i][BW-1-DW*int'(cnt[i]) -: DW] <= in_data_i;
              cnt[i] <= cnt[i] + 1'b1;
            end
      end
      if (state == S_RUN) wd_q <= wd_q + 1'b1;
      else                wd_q <= '0;
      if (run_done) begin
        nvc_q <= core_nvc_i;
        for (int k = 0; k < NNZ_MAX; k++) begin
          cic_q[4*k +: 4] <= core_cic_i[BW-DW*(k+1) +: 4];
          rpc_q[4*k +: 4] <= core_rpc_i[BW-DW*(k+1) +: 4];
        end
      end else if (run_timeout) begin
        err_to_q <= 1'b1;
      end
      if (out_fire) beat_q <= beat_final ? '0 : beat_q + 1'b1;
    end
  end

  assign core_rows_a_o = rows_a_q;
  assign core_rows_b_o = rows_b_q;
  assign core_nva_o    = opbuf[0];
  assign core_cia_o    = opbuf[1];
  assign core_rpa_o    = opbuf[2];
  assign core_nvb_o    = opbuf[3];
  assign core_cib_o    = opbuf[4];
  assign core_rpb_o    = opbuf[5];

`ifdef SPMM_SEQ_PERF_EN
  logic [31:0] run_len;
  logic [15:0] perf_q;
  assign run_len = 32'(wd_q) + 32'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         perf_q <= '0;
    else if (run_done) perf_q <= (run_len > 32'h0000_FFFF) ? 16'hFFFF : run_len[15:0];
  end
  assign perf_cycles_o = perf_q;
`endif

endmodule
